sequence_checker: RTL

- Playback/verify companion to the button sequence recorder. The recorder captures a user's button sequence and replays it; this block works the other way round.
- It shows a 16-step target pattern on the LED, then captures the user's attempt on the button at the same step rate.
- It reports the mismatch count and a pass/fail flag. It sits between the board buttons/LED and the shared step-rate timing.

---
 rtl/sequence_checker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sequence_checker.sv
// Shows a 16-step target pattern on the LED, then captures the user's attempt
// on the main button at the same step rate and reports mismatches and pass/fail.
module sequence_checker #(
  parameter int          TICK_COUNT      = 1500000,
  parameter logic [15:0] DEFAULT_PATTERN = 16'hA5C3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        main,
  input  logic        use_ext,
  input  logic [15:0] pattern_in,
  output logic        led,
  output logic [3:0]  timer,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  errors
);

  localparam int CNT_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;

  typedef enum logic [2:0] {IDLE, SHOW, GAP, CAPTURE, RESULT} state_t;

  state_t            state_q, state_d;
  logic              start_m_q, start_s_q, start_dly_q;
  logic              main_m_q, main_s_q;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [3:0]        timer_q, timer_d;
  logic [4:0]        errors_q, errors_d;
  logic              pass_q, pass_d;
  logic              blink_q, blink_d;
  logic [15:0]       pat_q, pat_d;
  logic              tick, start_edge, miss;

  assign tick       = (tick_cnt_q == CNT_W'(TICK_COUNT - 1));
  assign start_edge = start_s_q & ~start_dly_q;
  assign miss       = main_s_q ^ pat_q[timer_q];

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    timer_d    = timer_q;
    errors_d   = errors_q;
    pass_d     = pass_q;
    blink_d    = blink_q;
    pat_d      = pat_q;
    case (state_q)
      IDLE, RESULT: begin
        // A start edge beats a coincident tick, so a restart always begins
        // with a full first step.
        if (start_edge) begin
          state_d    = SHOW;
          pat_d      = use_ext ? pattern_in : DEFAULT_PATTERN;
          timer_d    = 4'd0;
          errors_d   = 5'd0;
          tick_cnt_d = '0;
          pass_d     = 1'b0;
          blink_d    = 1'b0;
        end else if (state_q == RESULT && tick) begin
          blink_d = ~blink_q;
        end
      end
      SHOW: begin
        if (tick) begin
          if (timer_q == 4'd15) begin
            state_d = GAP;
            timer_d = 4'd0;
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          state_d = CAPTURE;
          timer_d = 4'd0;
        end
      end
      CAPTURE: begin
        if (tick) begin
          errors_d = errors_q + {4'd0, miss};
          if (timer_q == 4'd15) begin
            state_d = RESULT;
            timer_d = 4'd0;
            pass_d  = (errors_d == 5'd0);
            blink_d = 1'b1;
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      start_m_q   <= 1'b0;
      start_s_q   <= 1'b0;
      start_dly_q <= 1'b0;
      main_m_q    <= 1'b0;
      main_s_q    <= 1'b0;
      tick_cnt_q  <= '0;
      timer_q     <= 4'd0;
      errors_q    <= 5'd0;
      pass_q      <= 1'b0;
      blink_q     <= 1'b0;
      pat_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      start_m_q   <= start;
      start_s_q   <= start_m_q;
      start_dly_q <= start_s_q;
      main_m_q    <= main;
      main_s_q    <= main_m_q;
      tick_cnt_q  <= tick_cnt_d;
      timer_q     <= timer_d;
      errors_q    <= errors_d;
      pass_q      <= pass_d;
      blink_q     <= blink_d;
      pat_q       <= pat_d;
    end
  end

  always_comb begin
    case (state_q)
      SHOW:    led = pat_q[timer_q];
      CAPTURE: led = main_s_q;
      RESULT:  led = pass_q | blink_q;
      default: led = 1'b0;
    endcase
  end

  assign timer  = timer_q;
  assign busy   = (state_q == SHOW) || (state_q == GAP) || (state_q == CAPTURE);
  assign done   = (state_q == RESULT);
  assign pass   = pass_q;
  assign errors = errors_q;

endmodule
